// File: rtl/pb_pkg.sv
// Shared types and default timing for the push-button conditioning path.
package pb_pkg;

  // Debounce FSM states: released, checking press, pressed, checking release.
  typedef enum logic [1:0] {REL, CHK_P, PRS, CHK_R} pb_state_t;

  // 20 ms and 1 s at a 50 MHz system clock.
  localparam int unsigned PB_DB_CYCLES_DEF   = 1_000_000;
  localparam int unsigned PB_LONG_CYCLES_DEF = 50_000_000;

endpackage

// File: rtl/pb_sync.sv
// Two-flop synchroniser for an asynchronous pad input.
// Resets to 1 so that an active-low pad reads as idle out of reset.
module pb_sync
  import pb_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic s1_q;
  logic s2_q;

  // Two-stage metastability filter; only the second stage leaves this block.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= 1'b1;
      s2_q <= 1'b1;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end

  assign q_o = s2_q;

endmodule

// File: rtl/pb_debounce.sv
// Push-button debouncer: synchronises the active-low pad, filters it with a
// stable-time counter FSM and produces a registered clean level plus a
// one-clock press pulse.
// Optional long-press pulse is built when PB_LONG_PRESS_EN is defined;
// otherwise long_press is tied low.
module pb_debounce
  import pb_pkg::*;
#(
  parameter int unsigned DB_CYCLES   = PB_DB_CYCLES_DEF,
  parameter int unsigned LONG_CYCLES = PB_LONG_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic PB_raw,
  output logic PB_db,
  output logic press_pulse,
  output logic long_press
);

  localparam int unsigned DB_W = $clog2(DB_CYCLES);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

  // Reject parameter sets the counters cannot represent.
  if (DB_CYCLES < 2 || LONG_CYCLES <= DB_CYCLES) begin : g_bad_params
    $error("pb_debounce: need DB_CYCLES >= 2 and LONG_CYCLES > DB_CYCLES");
  end

  logic            s2;
  pb_state_t       state_q, state_d;
  logic [DB_W-1:0] db_cnt_q, db_cnt_d;
  logic            pb_db_q, pb_db_d;
  logic            press_q, press_d;

  pb_sync u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (PB_raw),
    .q_o   (s2)
  );

  // FSM state, stable-time counter and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= REL;
      db_cnt_q <= '0;
      pb_db_q  <= 1'b1;
      press_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      db_cnt_q <= db_cnt_d;
      pb_db_q  <= pb_db_d;
      press_q  <= press_d;
    end
  end

  // Next-state logic: a level change is accepted only after DB_CYCLES
  // consecutive opposite samples in a CHK state; any bounce aborts the check.
  always_comb begin
    state_d  = state_q;
    db_cnt_d = db_cnt_q;
    pb_db_d  = pb_db_q;
    press_d  = 1'b0;
    unique case (state_q)
      REL: begin
        pb_db_d = 1'b1;
        if (!s2) begin
          state_d  = CHK_P;
          db_cnt_d = '0;
        end
      end
      CHK_P: begin
        if (!s2) begin
          if (db_cnt_q == DB_LAST) begin
            state_d  = PRS;
            db_cnt_d = '0;
            pb_db_d  = 1'b0;
            press_d  = 1'b1;
          end else begin
            db_cnt_d = db_cnt_q + 1'b1;
          end
        end else begin
          state_d  = REL;
          db_cnt_d = '0;
        end
      end
      PRS: begin
        pb_db_d = 1'b0;
        if (s2) begin
          state_d  = CHK_R;
          db_cnt_d = '0;
        end
      end
      CHK_R: begin
        if (s2) begin
          if (db_cnt_q == DB_LAST) begin
            state_d  = REL;
            db_cnt_d = '0;
            pb_db_d  = 1'b1;
          end else begin
            db_cnt_d = db_cnt_q + 1'b1;
          end
        end else begin
          // Release bounce: back to pressed without a new press pulse.
          state_d  = PRS;
          db_cnt_d = '0;
        end
      end
      default: begin
        state_d  = REL;
        db_cnt_d = '0;
        pb_db_d  = 1'b1;
      end
    endcase
  end

  assign PB_db       = pb_db_q;
  assign press_pulse = press_q;

`ifdef PB_LONG_PRESS_EN
  // One extra count value above LONG_CYCLES-1 marks "already fired".
  localparam int unsigned HOLD_W = $clog2(LONG_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_SAT  = HOLD_W'(LONG_CYCLES);

  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic              long_q, long_d;

  // Hold-time counter and long-press pulse register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt_q <= '0;
      long_q     <= 1'b0;
    end else begin
      hold_cnt_q <= hold_cnt_d;
      long_q     <= long_d;
    end
  end

  // Count clocks of accepted press (PRS and CHK_R); fire once, then saturate.
  always_comb begin
    hold_cnt_d = hold_cnt_q;
    long_d     = 1'b0;
    if (state_q == REL || (state_q == CHK_P && state_d == PRS)) begin
      hold_cnt_d = '0;
    end else if (state_q == PRS || state_q == CHK_R) begin
      if (hold_cnt_q == HOLD_LAST) begin
        long_d     = 1'b1;
        hold_cnt_d = HOLD_SAT;
      end else if (hold_cnt_q != HOLD_SAT) begin
        hold_cnt_d = hold_cnt_q + 1'b1;
      end
    end
  end

  assign long_press = long_q;
`else
  assign long_press = 1'b0;
`endif

endmodule

// File: tb/tb_pb_debounce.sv
// Directed bench for pb_debounce with DB_CYCLES=4, LONG_CYCLES=10.
// A stable-run model of the button predicts every output each cycle;
// literal checks pin the key latencies and pulse counts.
module tb_pb_debounce;

  localparam int DB   = 4;
  localparam int LONG = 10;
`ifdef PB_LONG_PRESS_EN
  localparam int LONG_EN = 1;
`else
  localparam int LONG_EN = 0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  logic PB_raw;
  logic PB_db;
  logic press_pulse;
  logic long_press;

  int errors = 0;
  int checks = 0;
  bit cmp_en = 1'b0;

  pb_debounce #(
    .DB_CYCLES   (DB),
    .LONG_CYCLES (LONG)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .PB_raw      (PB_raw),
    .PB_db       (PB_db),
    .press_pulse (press_pulse),
    .long_press  (long_press)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Model: the filter sees the pad two clocks late; the clean level flips
  // once DB+1 consecutive seen samples disagree with it. Long press fires
  // when the clean level has been low for LONG clocks.
  logic d1, d2, smp;
  logic m_db, m_press, m_long;
  int   run, hold;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d1 = 1'b1; d2 = 1'b1;
      m_db = 1'b1; m_press = 1'b0; m_long = 1'b0;
      run = 0; hold = 0;
    end else begin
      smp = d2;
      d2  = d1;
      d1  = PB_raw;
      m_press = 1'b0;
      m_long  = 1'b0;
      if (!m_db) begin
        hold++;
        if (hold == LONG && LONG_EN == 1) m_long = 1'b1;
      end
      if (smp != m_db) run++;
      else run = 0;
      if (run == DB + 1) begin
        m_db = ~m_db;
        run  = 0;
        if (!m_db) begin
          m_press = 1'b1;
          hold    = 0;
        end
      end
    end
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("cmp_PB_db", PB_db, m_db);
      chk("cmp_press_pulse", press_pulse, m_press);
      chk("cmp_long_press", long_press, m_long);
    end
  end

  // Event counters sampled just after each edge.
  int   cnt_press = 0;
  int   cnt_long  = 0;
  int   cnt_rise  = 0;
  logic prev_db   = 1'b1;
  always @(posedge clk) begin
    #1;
    if (press_pulse) cnt_press++;
    if (long_press)  cnt_long++;
    if (PB_db && !prev_db) cnt_rise++;
    prev_db = PB_db;
  end

  initial begin
    rst_n  = 1'b0;
    PB_raw = 1'b1;
    tick(3);
    cmp_en = 1'b1;
    chk("reset_PB_db", PB_db, 1);
    chk("reset_press", press_pulse, 0);
    chk("reset_long", long_press, 0);
    rst_n = 1'b1;
    tick(5);

    // Clean press held 30 clocks, then clean release.
    PB_raw = 1'b0;
    tick(6);
    chk("press_db_edge6", PB_db, 1);
    tick(1);
    chk("press_db_edge7", PB_db, 0);
    chk("press_pulse_edge7", press_pulse, 1);
    chk("model_db_edge7", m_db, 0);
    tick(1);
    chk("press_pulse_edge8", press_pulse, 0);
    tick(8);
    chk("long_edge16", long_press, 0);
    tick(1);
    chk("long_edge17", long_press, LONG_EN);
    chk("model_long_edge17", m_long, LONG_EN);
    tick(13);
    chk("long_once", cnt_long, LONG_EN);
    PB_raw = 1'b1;
    tick(6);
    chk("release_db_edge6", PB_db, 0);
    tick(1);
    chk("release_db_edge7", PB_db, 1);
    tick(10);

    // Short bounce: low 3 clocks is rejected.
    PB_raw = 1'b0;
    tick(3);
    PB_raw = 1'b1;
    tick(12);
    chk("bounce_db", PB_db, 1);
    chk("bounce_press_cnt", cnt_press, 1);

    // Press, then release with a bounce (high 2, low 1, high).
    PB_raw = 1'b0;
    tick(10);
    chk("rb_pressed", PB_db, 0);
    chk("rb_press_cnt", cnt_press, 2);
    PB_raw = 1'b1;
    tick(2);
    PB_raw = 1'b0;
    tick(1);
    PB_raw = 1'b1;
    tick(6);
    chk("rb_db_edge6", PB_db, 0);
    tick(1);
    chk("rb_db_edge7", PB_db, 1);
    chk("rb_no_second_press", cnt_press, 2);
    tick(10);

    // Back-to-back presses separated by 8 high clocks.
    for (int p = 0; p < 2; p++) begin
      PB_raw = 1'b0;
      tick(12);
      PB_raw = 1'b1;
      tick(8);
    end
    tick(10);
    chk("b2b_press_cnt", cnt_press, 4);
    chk("b2b_rise_cnt", cnt_rise, 3 + 1);
    chk("b2b_long_cnt", cnt_long, 4 * LONG_EN);

    // Reset asserted mid-count in CHK_P (db_cnt = 2).
    PB_raw = 1'b0;
    tick(5);
    #2 rst_n = 1'b0;
    #1;
    chk("rstmid_db", PB_db, 1);
    chk("rstmid_press", press_pulse, 0);
    chk("rstmid_long", long_press, 0);
    PB_raw = 1'b1;
    tick(1);
    rst_n = 1'b1;
    tick(20);
    chk("rstmid_idle_db", PB_db, 1);
    chk("rstmid_press_cnt", cnt_press, 4);

    // Pad held low through reset release: normal debounce latency.
    #2 rst_n = 1'b0;
    PB_raw = 1'b0;
    tick(1);
    rst_n = 1'b1;
    tick(6);
    chk("rstlow_db_edge6", PB_db, 1);
    tick(1);
    chk("rstlow_db_edge7", PB_db, 0);
    chk("rstlow_press", press_pulse, 1);
    PB_raw = 1'b1;
    tick(10);
    chk("final_press_cnt", cnt_press, 5);
    chk("final_rise_cnt", cnt_rise, 5);
    chk("final_long_cnt", cnt_long, 4 * LONG_EN);

    cmp_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pb_debounce.md
Name: pb_debounce

Overview:
Upstream conditioning stage for the push-button path. It synchronises the raw, bouncing pad signal, filters it with a stable-time counter FSM, and produces a clean level `PB_db`. `PB_db` feeds the release-edge detector directly.
- Also provides a single-cycle press pulse.
- Also provides an optional long-press pulse for the mode/power logic.
- Button is active-low: idle/released = 1.

Parameters:
DB_CYCLES, 1_000_000, consecutive stable clocks required to accept a level change (20 ms @ 50 MHz); legal range >= 2
LONG_CYCLES, 50_000_000, clocks `PB_db` must stay low before `long_press` fires (1 s @ 50 MHz); legal range > DB_CYCLES
(counter widths derived via $clog2 of each parameter)

Ports:
clk  input  1  system clock
rst_n  input  1  reset, asynchronous, active-low
PB_raw  input  1  raw asynchronous button pad, active-low
PB_db  output  1  debounced level; 1 = released, 0 = pressed
press_pulse  output  1  one-clock pulse on accepted press (`PB_db` 1->0)
long_press  output  1  one-clock pulse after LONG_CYCLES of continuous accepted press

Behaviour:
Reset values:
- All flops reset asynchronously.
- Synchroniser flops = 1; FSM = REL; counters = 0.
- `PB_db` = 1; `press_pulse` = 0; `long_press` = 0.

Synchroniser:
- 2 flops, `PB_raw` -> s1 -> s2.
- Only s2 is used downstream.

FSM (registered), states REL, CHK_P, PRS, CHK_R:
- REL: `PB_db` = 1. s2 = 0 -> CHK_P, db_cnt <= 0. Otherwise stay.
- CHK_P, with s2 = 0:
  - db_cnt == DB_CYCLES-1 -> PRS; `PB_db` <= 0 and `press_pulse` <= 1 on the same edge.
  - Otherwise db_cnt++.
- CHK_P, with s2 = 1: -> REL, db_cnt <= 0 (bounce rejected, no output change).
- PRS: `PB_db` = 0. s2 = 1 -> CHK_R, db_cnt <= 0. Otherwise stay.
- CHK_R, with s2 = 1: db_cnt == DB_CYCLES-1 -> REL, `PB_db` <= 1. Otherwise db_cnt++.
- CHK_R, with s2 = 0: -> PRS, db_cnt <= 0; `press_pulse` not re-fired.

Latency:
- `PB_raw` change held stable -> `PB_db` changes exactly DB_CYCLES+3 clocks later.
- Breakdown: 2 sync + 1 FSM entry + DB_CYCLES count.

Output rules:
- `press_pulse` high exactly 1 clock per accepted press, coincident with the `PB_db` falling edge.
- `PB_db` is glitch-free: driven from a flop, never combinational from the FSM.
- A bounce shorter than DB_CYCLES clocks produces no change on any output.

Boundary conditions:
- db_cnt never exceeds DB_CYCLES-1.
- db_cnt is cleared on every CHK entry or abort.
- Reset asserted mid-count or mid-press: immediate return to REL, `PB_db` = 1, no pulses emitted on reset release.
- `PB_raw` held low through reset deassert: normal debounce applies; a press is accepted after DB_CYCLES+3 clocks.

Optional Feature:
Macro PB_LONG_PRESS_EN.

Defined:
- hold_cnt counts clocks while FSM is in PRS or CHK_R.
- hold_cnt is cleared on entry to PRS from CHK_P and in REL.
- When hold_cnt reaches LONG_CYCLES-1, `long_press` pulses 1 clock and hold_cnt saturates.
- Only one `long_press` fires per press.
- A CHK_R bounce back to PRS does not clear hold_cnt.

Undefined:
- No hold_cnt logic is generated.
- `long_press` is tied to 0.

Decomposition:
Package `pb_pkg`:
- typedef enum logic [1:0] {REL, CHK_P, PRS, CHK_R} pb_state_t.
- localparam defaults PB_DB_CYCLES_DEF and PB_LONG_CYCLES_DEF.

Sub-module `pb_sync`:
- 2-flop synchroniser with reset value 1.
- Instantiated once; reusable for other pad inputs.

Test Plan:
(Run with DB_CYCLES=4, LONG_CYCLES=10, macro defined unless noted.)
- Clean press: `PB_raw` 1->0, held low -> `PB_db` falls 7 clocks after the edge; `press_pulse` high exactly that 1 clock.
- Bounce: `PB_raw` low 3 clocks then high -> `PB_db` stays 1, `press_pulse` never asserts, FSM returns to REL.
- Release bounce: from pressed, `PB_raw` high 2 clocks, low 1, then high -> `PB_db` rises 7 clocks after the final rising edge; no second `press_pulse`.
- Long press: hold low 30 clocks -> `long_press` one pulse 10 clocks after `PB_db` fell, no repeat; macro undefined -> `long_press` constantly 0.
- Reset mid-count: assert rst_n low while in CHK_P (db_cnt = 2) -> `PB_db` = 1 and all pulses 0 immediately; after release with `PB_raw` = 1 the block stays idle.
- Back-to-back presses: two clean presses separated by 8 high clocks -> exactly two `press_pulse`s and two full `PB_db` low/high cycles.
